// File: rtl/out_channel_pkg.sv
// Shared definitions for the out-channel reader: default word width, the word
// type and the ring pointer width helper.
package out_channel_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    // A one-entry ring still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/out_channel_if.sv
// Valid/ready word channel used on both sides of the out-channel reader:
// the producer holds the master modport and the receiver holds the slave modport.
interface out_channel_if
    import out_channel_pkg::*;
#(
    parameter int Width = MemoryElementWidth
);
    logic             valid;
    logic             ready;
    logic [Width-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/out_ring.sv
// Ring buffer for out-channel words: storage array, wrapping read/write
// pointers, occupancy count and full/empty flags. No bypass between ports.
module out_ring
    import out_channel_pkg::*;
#(
    parameter int Width = MemoryElementWidth,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);
    localparam int PtrWidth = ptr_width(Depth);
    localparam int CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wp;
    logic [PtrWidth-1:0] rp;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] cnt_next;
    logic                do_push;
    logic                do_pop;

    assign full       = (cnt == FullCnt);
    assign empty      = (cnt == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_data  = mem[rp];
    assign empty_next = (cnt_next == '0);

    // NOTE: cnt_next takes its hold value before any branch, so every path
    // assigns it and no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (do_push && !do_pop) begin
            cnt_next = cnt + CntWidth'(1);
        end else if (do_pop && !do_push) begin
            cnt_next = cnt - CntWidth'(1);
        end
    end

    // NOTE: non-blocking assignments let every flop sample pre-edge values,
    // independent of statement order within the block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= (wp == LastPtr) ? '0 : wp + PtrWidth'(1);
            end
            if (do_pop) begin
                rp <= (rp == LastPtr) ? '0 : rp + PtrWidth'(1);
            end
            cnt <= cnt_next;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after a
    // push has written it, so clearing it would buy nothing.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wp] <= push_data;
        end
    end

endmodule

// File: rtl/out_channel_reader.sv
// Receiving end of the program out channel: rings engine words to a consumer,
// counts deliveries, tracks drain. Optional checker: OUT_CHANNEL_READER_CHECK_EN.
module out_channel_reader #(
    parameter int MemoryElementWidth = out_channel_pkg::MemoryElementWidth,
    parameter int NOut               = 4,
    parameter int CountWidth         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    out_channel_if.slave                  out_ch,
    out_channel_if.master                 rd_ch,
    input  logic                          finished,
    output logic [CountWidth-1:0]         word_count,
    output logic                          drained,
    input  logic [MemoryElementWidth-1:0] exp_data,
    output logic                          mismatch,
    output logic                          success
);
    import out_channel_pkg::*;

    localparam logic [CountWidth-1:0] CountMax = '1;

    logic                          push;
    logic                          pop;
    logic                          full;
    logic                          empty;
    logic                          empty_next;
    logic                          fin_seen;
    logic [MemoryElementWidth-1:0] head_data;

    assign push         = out_ch.valid && !full;
    assign pop          = rd_ch.ready && !empty;
    assign out_ch.ready = !full;
    assign rd_ch.valid  = !empty;
    assign rd_ch.data   = head_data;

    out_ring #(
        .Width (MemoryElementWidth),
        .Depth (NOut)
    ) u_ring (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (out_ch.data),
        .pop        (pop),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty),
        .empty_next (empty_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fin_seen   <= 1'b0;
            word_count <= '0;
            drained    <= 1'b0;
        end else begin
            fin_seen <= fin_seen || finished;
            if (pop && (word_count != CountMax)) begin
                word_count <= word_count + CountWidth'(1);
            end
            // Next-state terms, so drained rises in the cycle after the last pop.
            drained <= (fin_seen || finished) && empty_next;
        end
    end

`ifdef OUT_CHANNEL_READER_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mismatch <= 1'b0;
        end else if (pop && (head_data != exp_data)) begin
            mismatch <= 1'b1;
        end
    end
`else
    logic unused_exp_data;
    assign unused_exp_data = ^exp_data;
    assign mismatch        = 1'b0;
`endif

    assign success = drained && !mismatch;

endmodule

// File: tb/tb_out_channel_reader.sv
// Self-checking bench for out_channel_reader: queue-based reference model,
// per-cycle compare, directed scenarios and randomized traffic with resets.
module tb_out_channel_reader;
    import out_channel_pkg::*;

    localparam int W          = MemoryElementWidth;
    localparam int NOut       = 4;
    localparam int CountWidth = 4;
    localparam int CountMax   = (1 << CountWidth) - 1;

    logic                  clock    = 1'b0;
    logic                  reset    = 1'b0;
    logic                  finished = 1'b0;
    logic [W-1:0]          exp_data = '0;
    logic [CountWidth-1:0] word_count;
    logic                  drained;
    logic                  mismatch;
    logic                  success;

    out_channel_if #(.Width(W)) out_ch ();
    out_channel_if #(.Width(W)) rd_ch ();

    out_channel_reader #(
        .MemoryElementWidth (W),
        .NOut               (NOut),
        .CountWidth         (CountWidth)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .out_ch     (out_ch),
        .rd_ch      (rd_ch),
        .finished   (finished),
        .word_count (word_count),
        .drained    (drained),
        .exp_data   (exp_data),
        .mismatch   (mismatch),
        .success    (success)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ring is a queue of at most NOut words.
    word_t m_q[$];
    bit    m_fin     = 1'b0;
    int    m_wc      = 0;
    bit    m_mis     = 1'b0;
    bit    m_drained = 1'b0;
    bit    m_pushed  = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_fin     = 1'b0;
            m_wc      = 0;
            m_mis     = 1'b0;
            m_drained = 1'b0;
            m_pushed  = 1'b0;
        end else begin
            bit acc;
            bit del;
            acc = out_ch.valid && (m_q.size() < NOut);
            del = rd_ch.ready && (m_q.size() > 0);
`ifdef OUT_CHANNEL_READER_CHECK_EN
            if (del && (m_q[0] != exp_data)) m_mis = 1'b1;
`endif
            if (del) begin
                void'(m_q.pop_front());
                if (m_wc < CountMax) m_wc++;
            end
            if (acc) m_q.push_back(out_ch.data);
            if (finished) m_fin = 1'b1;
            m_drained = m_fin && (m_q.size() == 0);
            m_pushed  = acc;
        end
    end

    // Outputs are all register-derived, so the falling edge is a stable point.
    always @(negedge clock) begin
        check("out_ready", 32'(out_ch.ready), 32'(m_q.size() < NOut));
        check("rd_valid", 32'(rd_ch.valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("rd_data", 32'(rd_ch.data), 32'(m_q[0]));
        check("word_count", 32'(word_count), 32'(m_wc));
        check("drained", 32'(drained), 32'(m_drained));
        check("mismatch", 32'(mismatch), 32'(m_mis));
        check("success", 32'(success), 32'(m_drained && !m_mis));
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    initial begin
        out_ch.valid = 1'b0;
        out_ch.data  = '0;
        rd_ch.ready  = 1'b0;

        repeat (3) tick();
        check("rst_out_ready", 32'(out_ch.ready), 32'd1);
        check("rst_rd_valid", 32'(rd_ch.valid), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        reset = 1'b1;
        tick();

        // Single word with the consumer stalled.
        out_ch.valid = 1'b1;
        out_ch.data  = W'(20);
        tick();
        out_ch.valid = 1'b0;
        check("t1_rd_valid", 32'(rd_ch.valid), 32'd1);
        check("t1_rd_data", 32'(rd_ch.data), 32'd20);
        rd_ch.ready = 1'b1;
        tick();
        rd_ch.ready = 1'b0;
        check("t1_word_count", 32'(word_count), 32'd1);
        check("t1_empty", 32'(rd_ch.valid), 32'd0);

        // Fill, hold a fifth word, pop while full, then drain across the wrap.
        for (int i = 1; i <= 4; i++) begin
            out_ch.valid = 1'b1;
            out_ch.data  = W'(i);
            tick();
        end
        check("t2_full", 32'(out_ch.ready), 32'd0);
        out_ch.data = W'(5);
        tick();
        tick();
        check("t2_held", 32'(out_ch.ready), 32'd0);
        check("t2_head", 32'(rd_ch.data), 32'd1);
        rd_ch.ready = 1'b1;
        tick();
        rd_ch.ready = 1'b0;
        check("t3_ready_after_pop", 32'(out_ch.ready), 32'd1);
        check("t3_head", 32'(rd_ch.data), 32'd2);
        tick();
        out_ch.valid = 1'b0;
        check("t2_full_again", 32'(out_ch.ready), 32'd0);
        rd_ch.ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("t2_order", 32'(rd_ch.data), 32'(i));
            tick();
        end
        rd_ch.ready = 1'b0;
        check("t2_drained_ring", 32'(rd_ch.valid), 32'd0);
        check("t2_word_count", 32'(word_count), 32'd6);

        // Finish then drain with a matching expected value.
        out_ch.valid = 1'b1;
        out_ch.data  = W'(2);
        finished     = 1'b1;
        tick();
        out_ch.valid = 1'b0;
        check("t4_not_drained", 32'(drained), 32'd0);
        rd_ch.ready = 1'b1;
        exp_data    = W'(2);
        tick();
        rd_ch.ready = 1'b0;
        check("t4_drained", 32'(drained), 32'd1);
        check("t4_success", 32'(success), 32'd1);

        // A push after finish clears drained; a wrong expected value follows.
        out_ch.valid = 1'b1;
        out_ch.data  = W'(7);
        tick();
        out_ch.valid = 1'b0;
        check("t5_push_clears_drained", 32'(drained), 32'd0);
        rd_ch.ready = 1'b1;
        exp_data    = W'(8);
        tick();
        rd_ch.ready = 1'b0;
        tick();
        tick();
`ifdef OUT_CHANNEL_READER_CHECK_EN
        check("t5_mismatch", 32'(mismatch), 32'd1);
        check("t5_success", 32'(success), 32'd0);
`else
        check("t5_mismatch", 32'(mismatch), 32'd0);
        check("t5_success", 32'(success), 32'd1);
`endif
        check("t5_word_count", 32'(word_count), 32'd8);

        // Asynchronous reset with words buffered, checked before any clock edge.
        finished = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            out_ch.valid = 1'b1;
            out_ch.data  = W'(10 + i);
            tick();
        end
        out_ch.valid = 1'b0;
        check("t6_buffered", 32'(rd_ch.valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t6_rd_valid", 32'(rd_ch.valid), 32'd0);
        check("t6_out_ready", 32'(out_ch.ready), 32'd1);
        check("t6_word_count", 32'(word_count), 32'd0);
        check("t6_drained", 32'(drained), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Randomized traffic in alternating fill/drain phases with periodic resets.
        for (int c = 0; c < 3000; c++) begin
            bit fill_phase;
            fill_phase = (c % 500) < 250;
            if (!out_ch.valid || m_pushed) begin
                out_ch.valid = fill_phase ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
                out_ch.data  = W'($urandom);
            end
            rd_ch.ready = fill_phase ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
            if ((m_q.size() != 0) && ($urandom_range(15) != 0)) exp_data = m_q[0];
            else exp_data = W'($urandom);
            if ($urandom_range(150) == 0) finished = 1'b1;
            tick();
            if ((c % 500) == 499) begin
                #1 reset = 1'b0;
                finished = 1'b0;
                tick();
                reset = 1'b1;
            end
        end

        out_ch.valid = 1'b0;
        rd_ch.ready  = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
